// File: rtl/aes_pkg.sv
// Shared Rijndael helpers: row-shift offsets, the state byte layout and the
// pure ShiftRows/InvShiftRows permutation used by the round datapath.
package aes_pkg;

  localparam int unsigned NB_MAX = 8;
  // Bit n set means NB = n is a supported block width (4, 6 and 8 columns).
  localparam logic [NB_MAX:0] LEGAL_NB_MASK = 9'b1_0101_0000;

  // Indexed [col][row]; byte k = 4*col + row sits at bits [8k+:8].
  typedef logic [NB_MAX-1:0][3:0][7:0] state_t;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_ONE,
    OCC_FULL
  } occ_e;

  function automatic bit nb_is_legal(input int unsigned nb);
    return (nb <= NB_MAX) && LEGAL_NB_MASK[nb[3:0]];
  endfunction

  function automatic int unsigned shift_offset(input int unsigned nb, input int unsigned row);
    // Only the 256-bit block skips offset 2: rows 2 and 3 move by 3 and 4.
    if ((nb == 8) && (row >= 2)) begin
      return row + 1;
    end
    return row;
  endfunction

  function automatic state_t shift_state(input state_t s, input int unsigned nb, input bit inv);
    state_t      res;
    int unsigned off;
    int unsigned src;
    res = '0;
    for (int unsigned c = 0; c < NB_MAX; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        if (c < nb) begin
          off = shift_offset(nb, r);
          src = inv ? ((c + nb - off) % nb) : ((c + off) % nb);
          res[c][r] = s[src][r];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry valid/ready buffer; both ready and valid come straight from flops
// so neither side sees a combinational path through the other.
module skid_buf2
  import aes_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [W-1:0] i_in_data,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [W-1:0] o_out_data
);

  occ_e         r_state;
  logic [W-1:0] r_head;
  logic [W-1:0] r_skid;
  logic         r_in_ready;
  logic         r_out_valid;

  logic w_accept;
  logic w_deliver;

  assign w_accept  = i_in_valid && r_in_ready;
  assign w_deliver = r_out_valid && i_out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= OCC_EMPTY;
      r_head      <= '0;
      r_skid      <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        OCC_EMPTY: begin
          // Also the first edge after reset, when ready rises.
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_head      <= i_in_data;
            r_out_valid <= 1'b1;
            r_state     <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (w_accept && !w_deliver) begin
            r_skid     <= i_in_data;
            r_in_ready <= 1'b0;
            r_state    <= OCC_FULL;
          end else if (!w_accept && w_deliver) begin
            r_out_valid <= 1'b0;
            r_state     <= OCC_EMPTY;
          end else if (w_accept) begin
            r_head <= i_in_data;
          end
        end
        OCC_FULL: begin
          if (w_deliver) begin
            r_head     <= r_skid;
            r_in_ready <= 1'b1;
            r_state    <= OCC_ONE;
          end
        end
        default: begin
          r_state     <= OCC_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_head;

endmodule

// File: rtl/shift_rows_pipe.sv
// Registered ShiftRows stage: the permutation is applied on the way in and the
// result, with its tag, is held in a 2-entry skid buffer; counts deliveries.
module shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int unsigned NB    = 4,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [32*NB-1:0]  in_data,
  input  logic              in_inv,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [32*NB-1:0]  out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic [CNT_W-1:0]  blk_count,
  input  logic              clr_count
);

  localparam int unsigned DATA_W = 32 * NB;
  localparam int unsigned PAY_W  = DATA_W + TAG_W;

  if (!nb_is_legal(NB)) begin : g_bad_nb
    $fatal(1, "shift_rows_pipe: NB must be 4, 6 or 8");
  end

  logic [DATA_W-1:0] w_shifted;
  logic [PAY_W-1:0]  w_in_payload;
  logic [PAY_W-1:0]  w_out_payload;
  logic              w_out_valid;
  logic [CNT_W-1:0]  r_blk_count;

  always_comb begin
    state_t v_state;
    v_state          = '0;
    v_state[NB-1:0]  = in_data;
    v_state          = shift_state(v_state, NB, in_inv);
    w_shifted        = v_state[NB-1:0];
  end

  assign w_in_payload = {in_tag, w_shifted};

  skid_buf2 #(
    .W (PAY_W)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_data   (w_in_payload),
    .o_out_valid (w_out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (w_out_payload)
  );

  // A clear in the same cycle as a delivery takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blk_count <= '0;
    end else if (clr_count) begin
      r_blk_count <= '0;
    end else if (w_out_valid && out_ready) begin
      r_blk_count <= r_blk_count + CNT_W'(1);
    end
  end

  assign out_valid = w_out_valid;
  assign out_data  = w_out_payload[DATA_W-1:0];
  assign out_tag   = w_out_payload[PAY_W-1:DATA_W];
  assign blk_count = r_blk_count;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Directed bench for shift_rows_pipe: three instances (NB=4/6/8) share control
// so one stimulus sequence exercises all block widths.
module tb_shift_rows_pipe;

  localparam logic [127:0] FIPS_IN   = 128'h3052411ee55db4b8f198bfe0ae1127d4;
  localparam logic [127:0] FIPS_OUT  = 128'he598271ef11141b8ae52b4e0305dbfd4;
  localparam logic [127:0] RAMP4_OUT = 128'h0B06010C07020D08030E09040F0A0500;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_inv;
  logic [3:0]   in_tag;
  logic         out_ready;
  logic         clr_count;
  logic [127:0] d4_in;
  logic [191:0] d6_in;
  logic [255:0] d8_in;

  logic         rdy4, rdy6, rdy8;
  logic         vld4, vld6, vld8;
  logic [127:0] q4;
  logic [191:0] q6;
  logic [255:0] q8;
  logic [3:0]   tag4, tag6, tag8;
  logic [15:0]  cnt4, cnt8;
  logic [2:0]   cnt6;

  int n_total = 0;
  int n_bad   = 0;

  logic [255:0] ramp;
  logic [127:0] hold4;
  logic [255:0] r8, f8;
  logic [191:0] r6, f6;
  logic [127:0] r4, f4;

  shift_rows_pipe #(.NB(4), .TAG_W(4), .CNT_W(16)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4), .in_data(d4_in),
    .in_inv(in_inv), .in_tag(in_tag), .out_valid(vld4), .out_ready(out_ready),
    .out_data(q4), .out_tag(tag4), .blk_count(cnt4), .clr_count(clr_count)
  );

  shift_rows_pipe #(.NB(6), .TAG_W(4), .CNT_W(3)) u_dut6 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy6), .in_data(d6_in),
    .in_inv(in_inv), .in_tag(in_tag), .out_valid(vld6), .out_ready(out_ready),
    .out_data(q6), .out_tag(tag6), .blk_count(cnt6), .clr_count(clr_count)
  );

  shift_rows_pipe #(.NB(8), .TAG_W(4), .CNT_W(16)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8), .in_data(d8_in),
    .in_inv(in_inv), .in_tag(in_tag), .out_valid(vld8), .out_ready(out_ready),
    .out_data(q8), .out_tag(tag8), .blk_count(cnt8), .clr_count(clr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [255:0] a8, input logic [191:0] a6, input logic [127:0] a4,
                       input logic [3:0] t, input logic inv);
    in_valid = 1'b1;
    d8_in    = a8;
    d6_in    = a6;
    d4_in    = a4;
    in_tag   = t;
    in_inv   = inv;
  endtask

  // Starts and ends at a falling edge; on return the block is on out_* if the
  // buffer was empty.
  task automatic send(input logic [255:0] a8, input logic [191:0] a6, input logic [127:0] a4,
                      input logic [3:0] t, input logic inv);
    int w;
    drive(a8, a6, a4, t, inv);
    w = 0;
    while (!rdy4 && (w < 20)) begin
      @(negedge clk);
      w++;
    end
    chk("accept_timeout", 256'(w < 20), 256'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_inv = 1'b0; in_tag = '0; out_ready = 1'b0;
    clr_count = 1'b0; d4_in = '0; d6_in = '0; d8_in = '0;
    for (int k = 0; k < 32; k++) ramp[8*k+:8] = 8'(k);

    #12;
    chk("rst_in_ready", 256'(rdy4), 256'(0));
    chk("rst_out_valid", 256'(vld4), 256'(0));
    chk("rst_out_data", 256'(q4), 256'(0));
    chk("rst_count", 256'(cnt4), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 256'(rdy4), 256'(1));

    // FIPS-197 vector forward, then inverse recovers the input.
    out_ready = 1'b1;
    send(ramp, ramp[191:0], FIPS_IN, 4'd3, 1'b0);
    chk("fips_fwd_valid", 256'(vld4), 256'(1));
    chk("fips_fwd_data", 256'(q4), 256'(FIPS_OUT));
    chk("fips_fwd_tag", 256'(tag4), 256'(3));
    chk("nb8_col0", 256'(q8[31:0]), 256'(32'h130E0500));
    chk("nb8_col7", 256'(q8[255:224]), 256'(32'h0F0A011C));
    chk("nb6_col5", 256'(q6[191:160]), 256'(32'h0B060114));
    send(ramp, ramp[191:0], FIPS_OUT, 4'd4, 1'b1);
    chk("fips_inv_data", 256'(q4), 256'(FIPS_IN));
    chk("fips_inv_tag", 256'(tag4), 256'(4));
    @(negedge clk);
    chk("drained", 256'(vld4), 256'(0));

    // Backpressure: two accepted, third held off, then in-order drain.
    out_ready = 1'b0;
    drive(ramp, ramp[191:0], FIPS_IN, 4'd1, 1'b0);
    chk("bp_rdy1", 256'(rdy4), 256'(1));
    @(negedge clk);
    drive(ramp, ramp[191:0], FIPS_OUT, 4'd2, 1'b0);
    chk("bp_rdy2", 256'(rdy4), 256'(1));
    chk("bp_head_tag", 256'(tag4), 256'(1));
    @(negedge clk);
    drive(ramp, ramp[191:0], ramp[127:0], 4'd3, 1'b0);
    chk("bp_rdy3_low", 256'(rdy4), 256'(0));
    hold4 = q4;
    @(negedge clk);
    chk("bp_rdy_hold", 256'(rdy4), 256'(0));
    chk("bp_data_stable", 256'(q4), 256'(hold4));
    chk("bp_head_data", 256'(q4), 256'(FIPS_OUT));
    chk("bp_tag_hold", 256'(tag4), 256'(1));
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_deliver2", 256'(tag4), 256'(2));
    chk("bp_rdy_back", 256'(rdy4), 256'(1));
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_deliver3", 256'(tag4), 256'(3));
    chk("bp_data3", 256'(q4), 256'(RAMP4_OUT));
    @(negedge clk);
    chk("bp_empty", 256'(vld4), 256'(0));

    // Streaming with alternating mode: forward(FIPS_IN) and inverse(FIPS_OUT)
    // each produce the other vector.
    clr_count = 1'b1;
    @(negedge clk);
    clr_count = 1'b0;
    chk("clr_count", 256'(cnt4), 256'(0));
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        chk("st_valid", 256'(vld4), 256'(1));
        chk("st_ready", 256'(rdy4), 256'(1));
        chk("st_tag", 256'(tag4), 256'(i - 1));
        chk("st_data", 256'(q4), 256'((((i - 1) % 2) == 1) ? FIPS_IN : FIPS_OUT));
      end
      if (i < 8) drive(ramp, ramp[191:0], (i % 2 == 1) ? FIPS_OUT : FIPS_IN, 4'(i), i[0]);
      else in_valid = 1'b0;
      @(negedge clk);
    end
    chk("st_count8", 256'(cnt4), 256'(8));
    chk("st_count_wrap", 256'(cnt6), 256'(0));
    chk("st_empty", 256'(vld4), 256'(0));

    // Clear coinciding with a delivery.
    out_ready = 1'b0;
    drive(ramp, ramp[191:0], FIPS_IN, 4'd9, 1'b0);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clr_count = 1'b1;
    @(negedge clk);
    clr_count = 1'b0;
    chk("clr_wins", 256'(cnt4), 256'(0));
    chk("clr_delivered", 256'(vld4), 256'(0));
    send(ramp, ramp[191:0], FIPS_IN, 4'd10, 1'b0);
    @(negedge clk);
    chk("count_after_clr", 256'(cnt4), 256'(1));

    // Asynchronous reset while FULL.
    out_ready = 1'b0;
    drive(ramp, ramp[191:0], FIPS_IN, 4'd5, 1'b0);
    @(negedge clk);
    drive(ramp, ramp[191:0], FIPS_OUT, 4'd6, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("full_rdy", 256'(rdy4), 256'(0));
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 256'(vld4), 256'(0));
    chk("arst_count", 256'(cnt4), 256'(0));
    chk("arst_ready", 256'(rdy4), 256'(0));
    chk("arst_data", 256'(q4), 256'(0));
    chk("arst_tag", 256'(tag4), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_rdy_after", 256'(rdy4), 256'(1));
    chk("arst_still_empty", 256'(vld4), 256'(0));

    // Random forward-then-inverse round trips on all three widths.
    out_ready = 1'b1;
    for (int it = 0; it < 1000; it++) begin
      r8 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      r6 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      r4 = {$urandom, $urandom, $urandom, $urandom};
      send(r8, r6, r4, 4'(it), 1'b0);
      f8 = q8;
      f6 = q6;
      f4 = q4;
      send(f8, f6, f4, 4'(it + 1), 1'b1);
      chk("rt_nb4", 256'(q4), 256'(r4));
      chk("rt_nb6", 256'(q6), 256'(r6));
      chk("rt_nb8", q8, r8);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_rows_pipe.md
Name: shift_rows_pipe

Overview:
Parametrised, registered ShiftRows stage for the Rijndael round datapath. It supports block widths of 128, 192 and 256 bits (Nb = 4/6/8) and selects forward (encrypt) or inverse (decrypt) shift per transaction. It has valid/ready handshakes on both sides with a 2-entry skid buffer, so ready is fully registered. It sits between sub_bytes and mix_columns and carries a sideband tag so round-control logic can track blocks in flight.

Parameters:
NB, 4, number of 32-bit state columns; legal values 4, 6, 8; any other value is an elaboration error ($fatal)
TAG_W, 4, width of the sideband tag carried alongside each block
CNT_W, 16, width of the completed-block counter

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  upstream block valid
in_ready  output  1  stage can accept a block (registered)
in_data  input  32*NB  state bytes; byte k = bits [8k+:8]; k = 4*col + row
in_inv  input  1  0 = forward ShiftRows, 1 = InvShiftRows
in_tag  input  TAG_W  sideband tag, passed through unchanged
out_valid  output  1  output block valid
out_ready  input  1  downstream accepts the block
out_data  output  32*NB  shifted state, same byte layout as in_data
out_tag  output  TAG_W  tag of the block on out_data
blk_count  output  CNT_W  blocks delivered (out_valid && out_ready), wraps modulo 2^CNT_W
clr_count  input  1  synchronous clear of blk_count

Behaviour:
- Row shift offsets s_r for rows 0..3: NB=4 -> 0,1,2,3; NB=6 -> 0,1,2,3; NB=8 -> 0,1,3,4.
- Forward: out(r,c) = in(r, (c + s_r) mod NB). Inverse: out(r,c) = in(r, (c - s_r) mod NB). Column indices wrap modulo NB.
- The shift is combinational on the input side; the result is captured into the buffer. There are no arithmetic carries.
- Storage is a 2-entry FIFO of {data, tag}: head slot drives out_*, skid slot holds the second entry.
- Accept: in_valid && in_ready. Deliver: out_valid && out_ready.
- in_ready = 1 when the occupancy is 0 or 1. It is registered and is a function of occupancy only; it never depends combinationally on out_ready.
- Latency: a block accepted in cycle N appears on out_data with out_valid=1 in cycle N+1 when the buffer was empty.
- Throughput: 1 block/cycle sustained while out_ready=1.
- Occupancy FSM, states EMPTY, ONE, FULL:
  - EMPTY: accept -> ONE.
  - ONE: accept without deliver -> FULL; deliver without accept -> EMPTY; accept and deliver together -> ONE, and the new block becomes the head.
  - FULL: deliver -> ONE, skid moves to head. in_ready=0, so no accept is possible.
- Ordering: strictly FIFO. The in_inv choice is per block and is applied at capture; it never mixes across blocks.
- out_data and out_tag hold stable while out_valid=1 && out_ready=0.
- blk_count increments on each deliver. If clr_count and deliver occur in the same cycle, clr_count wins and the result is 0. The counter wraps from all-ones to 0.
- Reset (async assert, applies mid-transfer too): occupancy EMPTY, out_valid=0, in_ready=0 while rst=1, then in_ready=1 from the first clock after deassert. out_data=0, out_tag=0, blk_count=0. Blocks in flight are discarded.
- X-safety: out_data changes only on a head load; in_data is ignored when in_valid=0.

Decomposition:
- Package aes_pkg holds:
  - function shift_offset(nb, row), returning s_r;
  - localparam for the legal NB set;
  - typedef of the state byte array indexed [col][row];
  - function shift_state(state, nb, inv), the pure combinational permutation reused later by the key-expansion and decrypt paths.
- One sub-module is natural: skid_buf2 (2-entry valid/ready buffer, parametrised payload width = 32*NB+TAG_W). shift_rows_pipe = shift_state() feeding skid_buf2, plus the counter.

Test Plan:
- FIPS-197 vector, NB=4, forward:
  - Stimulus: bytes k0..k15 = d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30, tag=3.
  - Required: out bytes d4 bf 5d 30 e0 b4 52 ae b8 41 11 f1 1e 27 98 e5, tag=3, one cycle after accept.
- Inverse round trip: feed that output with in_inv=1 -> the original d4 27 11 ae... bytes are recovered. Also run 1000 random blocks through forward then inverse (NB=4/6/8) and check equality.
- NB=8 forward with byte k = k (0x00..0x1F):
  - Output column 0 must be 00 05 0E 13.
  - Output column 7 must be 1C 01 0A 0F; this checks the wrap and the row-2/3 offsets of 3/4.
- Backpressure: out_ready=0, send 3 consecutive valid blocks (tags 1,2,3):
  - Required: accept tags 1,2, in_ready=0 on the 3rd cycle and hold.
  - Then raise out_ready: deliver 1,2,3 in order, with out_data stable during the stall.
- Simultaneous accept/deliver in ONE state with alternating in_inv: stream 8 blocks with out_ready=1 -> 1 block/cycle, correct per-block mode, blk_count=8.
- Reset mid-stream: assert rst asynchronously (between edges) with FULL occupancy -> out_valid=0, blk_count=0 immediately, in_ready=1 after the first post-deassert edge. A clr_count coinciding with a deliver yields blk_count=0.
